// File: rtl/led_pkg.sv
// Shared encodings for the LED pattern generator: pattern modes, bounce direction
// and the per-mode seed rule used when a new mode is loaded.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT  = 2'd0,
    MODE_WALK   = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int PWM_W = 8;

  // WALK and BOUNCE start from a single lit LED; COUNT and BLINK start dark.
  function automatic logic seed_is_one(input mode_e m);
    return (m == MODE_WALK) || (m == MODE_BOUNCE);
  endfunction

endpackage

// File: rtl/led_pattern_gen_tick_div.sv
// Free-running prescaler: counts 0..DIV-1 and raises tick for the single cycle
// following each wrap. DIV=1 keeps tick high continuously after reset.
module tick_div #(
  parameter int DIV = 12_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int           W    = $clog2(DIV + 1);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (count == LAST) begin
      count <= '0;
      tick  <= 1'b1;
    end else begin
      count <= count + W'(1);
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: COUNT / WALK / BOUNCE / BLINK with pause,
// single-step and output polarity. Define LED_PWM_EN to add the bright duty input.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int N_LED      = 4,
  parameter int TICK_DIV   = 12_000_000,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             pause,
  input  logic             step,
`ifdef LED_PWM_EN
  input  logic [PWM_W-1:0] bright,
`endif
  output logic [N_LED-1:0] led,
  output logic             tick
);

  localparam logic [N_LED-1:0] ONE      = N_LED'(1);
  localparam logic [N_LED-1:0] ALL_ONES = '1;
  localparam logic [N_LED-1:0] POL      = {N_LED{ACTIVE_LOW}};

  mode_e            mode_req;
  mode_e            mode_q;
  mode_e            mode_q_next;
  dir_e             dir;
  dir_e             dir_next;
  logic [N_LED-1:0] pat;
  logic [N_LED-1:0] pat_next;
  logic [N_LED-1:0] lit;
  logic             adv;

  tick_div #(
    .DIV(TICK_DIV)
  ) u_tick_div (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // STEP only matters while paused, so the two sources can never both fire.
  assign adv = (tick & ~pause) | (step & pause);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_req <= MODE_COUNT;
      mode_q   <= MODE_COUNT;
      dir      <= DIR_UP;
      pat      <= '0;
    end else begin
      mode_req <= mode_e'(mode);
      mode_q   <= mode_q_next;
      dir      <= dir_next;
      pat      <= pat_next;
    end
  end

  always_comb begin
    mode_q_next = mode_q;
    dir_next    = dir;
    pat_next    = pat;
    if (adv) begin
      // A pending mode change consumes the advance: load the seed instead of stepping.
      if (mode_req != mode_q) begin
        mode_q_next = mode_req;
        dir_next    = DIR_UP;
        pat_next    = seed_is_one(mode_req) ? ONE : '0;
      end else begin
        unique case (mode_q)
          MODE_COUNT: begin
            pat_next = pat + ONE;
          end
          MODE_WALK: begin
            if (pat == '0) begin
              pat_next = ONE;
            end else begin
              pat_next = (pat << 1) | (pat >> (N_LED - 1));
            end
          end
          MODE_BOUNCE: begin
            if ((N_LED == 1) || (pat == '0)) begin
              pat_next = ONE;
              dir_next = DIR_UP;
            end else if (dir == DIR_UP) begin
              pat_next = pat << 1;
              if (pat_next[N_LED-1]) begin
                dir_next = DIR_DOWN;
              end
            end else begin
              pat_next = pat >> 1;
              if (pat_next[0]) begin
                dir_next = DIR_UP;
              end
            end
          end
          MODE_BLINK: begin
            pat_next = (pat == ALL_ONES) ? '0 : ALL_ONES;
          end
        endcase
      end
    end
  end

`ifdef LED_PWM_EN
  logic [PWM_W-1:0] pwm_cnt;
  logic [PWM_W-1:0] bright_q;
  logic [PWM_W-1:0] duty;

  // Brightness is captured at the start of each PWM period to avoid mid-period glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt  <= '0;
      bright_q <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      if (pwm_cnt == '0) begin
        bright_q <= bright;
      end
    end
  end

  assign duty = (pwm_cnt == '0) ? bright : bright_q;
  assign lit  = pat & {N_LED{pwm_cnt < duty}};
`else
  assign lit = pat;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= POL;
    end else begin
      led <= lit ^ POL;
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: stimulus queues expected LED values, a monitor
// pops one per LED change. LED_PWM_EN builds run the PWM duty checks instead.
module tb_led_pattern_gen;

  localparam int TICK_DIV = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode  = 2'd0;
  logic       pause = 1'b0;
  logic       step  = 1'b0;
  logic [3:0] led;
  logic       tick;

  logic [1:0] mode_al  = 2'd0;
  logic       pause_al = 1'b0;
  logic       step_al  = 1'b0;
  logic [3:0] led_al;
  logic       tick_al;

`ifdef LED_PWM_EN
  logic [7:0] bright    = 8'd255;
  logic [7:0] bright_al = 8'd64;
`endif

  logic [3:0] exp_q[$];
  int         compared   = 0;
  int         mismatched = 0;

  led_pattern_gen #(
    .N_LED(4), .TICK_DIV(TICK_DIV), .ACTIVE_LOW(1'b0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .mode (mode),
    .pause(pause),
    .step (step),
`ifdef LED_PWM_EN
    .bright(bright),
`endif
    .led  (led),
    .tick (tick)
  );

  led_pattern_gen #(
    .N_LED(4), .TICK_DIV(1), .ACTIVE_LOW(1'b1)
  ) dut_al (
    .clk  (clk),
    .rst_n(rst_n),
    .mode (mode_al),
    .pause(pause_al),
    .step (step_al),
`ifdef LED_PWM_EN
    .bright(bright_al),
`endif
    .led  (led_al),
    .tick (tick_al)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input int actual, input int required);
    compared++;
    if (actual != required) begin
      mismatched++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output({"drain_", name}, exp_q.size(), 0);
  endtask

  task automatic pulse_step();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Monitor: each LED change must match the head of the queue; ticks must be TICK_DIV apart.
  initial begin : monitor
    logic [3:0] last_led;
    logic [3:0] e;
    int         cyc;
    int         last_tick_cyc;
    bit         have_tick;
    last_led      = 4'b0000;
    cyc           = 0;
    last_tick_cyc = 0;
    have_tick     = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        have_tick = 1'b0;
      end else if (tick) begin
        if (have_tick) check_output("tick_period", cyc - last_tick_cyc, TICK_DIV);
        have_tick     = 1'b1;
        last_tick_cyc = cyc;
      end
      if (led !== last_led) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL led_unexpected actual=%b required=no_change(%b)", led, last_led);
        end else begin
          e = exp_q.pop_front();
          check_output("led_seq", int'(led), int'(e));
        end
        last_led = led;
      end
    end
  end

  initial begin : stimulus
    logic [3:0] al_led_tbl[5];
    int         low_cnt;
    al_led_tbl = '{4'hF, 4'hF, 4'hE, 4'hD, 4'hC};

`ifdef LED_PWM_EN
    pause    = 1'b1;
    pause_al = 1'b1;
    mode_al  = 2'd3;
`endif
    repeat (3) @(negedge clk);
    check_output("reset_led", int'(led), 'b0000);
    check_output("reset_tick", int'(tick), 0);
    check_output("reset_led_al", int'(led_al), 'b1111);

`ifndef LED_PWM_EN
    // COUNT from reset through a wrap.
    for (int v = 1; v <= 20; v++) exp_q.push_back(4'(v));
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("al_led", int'(led_al), int'(al_led_tbl[i]));
      check_output("al_tick", int'(tick_al), 1);
    end
    wait_drain("count", 120);
    pause = 1'b1;

    // BOUNCE load and full sweep.
    mode = 2'd2;
    repeat (2) @(negedge clk);
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0100); exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
    pause = 1'b0;
    wait_drain("bounce", 60);
    pause = 1'b1;

    // Step COUNT up to 0110 while paused, then switch to WALK.
    mode = 2'd0;
    repeat (2) @(negedge clk);
    for (int v = 0; v <= 6; v++) exp_q.push_back(4'(v));
    repeat (7) pulse_step();
    wait_drain("step_count", 10);
    mode = 2'd1;
    repeat (2) @(negedge clk);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    pause = 1'b0;
    wait_drain("walk_load", 30);
    pause = 1'b1;

    // Pause holds; one STEP gives exactly one advance, visible two cycles later.
    repeat (20) @(negedge clk);
    check_output("pause_hold", int'(led), 'b0010);
    exp_q.push_back(4'b0100);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    check_output("step_lat1", int'(led), 'b0010);
    @(negedge clk);
    check_output("step_lat2", int'(led), 'b0100);
    repeat (8) @(negedge clk);
    check_output("step_once", int'(led), 'b0100);

    // STEP held while running must be ignored.
    exp_q.push_back(4'b1000);
    step  = 1'b1;
    pause = 1'b0;
    wait_drain("step_ignored", 20);
    step  = 1'b0;
    pause = 1'b1;

    // Asynchronous reset in the middle of BOUNCE.
    mode = 2'd2;
    repeat (2) @(negedge clk);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    pause = 1'b0;
    wait_drain("bounce2", 40);
    @(posedge clk);
    #3;
    exp_q.push_back(4'b0000);
    rst_n = 1'b0;
    mode  = 2'd0;
    #1;
    check_output("async_reset_led", int'(led), 'b0000);
    check_output("async_reset_tick", int'(tick), 0);
    repeat (3) @(negedge clk);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0011);
    rst_n = 1'b1;
    wait_drain("post_reset", 30);
    pause = 1'b1;
    repeat (10) @(negedge clk);
    check_output("final_queue", exp_q.size(), 0);
`else
    // Active-low PWM: BLINK to 1111 by two steps, then count dark-pin (lit) cycles.
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      step_al = 1'b1;
      @(negedge clk);
      step_al = 1'b0;
      repeat (2) @(negedge clk);
    end
    check_output("pwm_pat_on", int'(led_al != 4'b0000 && led_al != 4'b1111), 0);
    low_cnt = 0;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      if (led_al == 4'b0000) low_cnt++;
    end
    check_output("pwm_low_64", low_cnt, 128);
    bright_al = 8'd0;
    repeat (300) @(negedge clk);
    low_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (led_al == 4'b0000) low_cnt++;
    end
    check_output("pwm_low_0", low_cnt, 0);
    bright_al = 8'd255;
    repeat (300) @(negedge clk);
    low_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (led_al == 4'b0000) low_cnt++;
    end
    check_output("pwm_low_255", low_cnt, 255);
    check_output("pwm_main_dark", int'(led), 'b0000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
